// File: rtl/sec60_ctrl.sv
// 60-second counter controller: 1 Hz prescaler, start/stop/clear sequencing,
// and a BCD seconds value 00-59 for a pair of blanking 7-segment decoders.
`timescale 1ns/1ps

// state   | meaning
// ST_STOP | prescaler held at 0, digits frozen
// ST_RUN  | prescaler counting, digits advance on each tick
module sec60_ctrl #(
    parameter int PRESCALE = 50000000,
    parameter int BLANK_LZ = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       CLR,
    output logic [3:0] DIG_L,
    output logic [3:0] DIG_H,
    output logic       CARRY,
    output logic       RUNNING
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [3:0]    ones, ones_nx;
    logic [3:0]    tens, tens_nx;
    logic          carry_nx;
    logic          start_q;
    logic          start_rise;
    logic          tick;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_STOP;
            presc   <= '0;
            ones    <= '0;
            tens    <= '0;
            CARRY   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            presc   <= presc_nx;
            ones    <= ones_nx;
            tens    <= tens_nx;
            CARRY   <= carry_nx;
            start_q <= START;
        end
    end

    always_comb begin
        start_rise = START & ~start_q;
        tick       = (state == ST_RUN) && (presc == PRESC_MAX);

        state_nx = state;
        presc_nx = '0;
        ones_nx  = ones;
        tens_nx  = tens;
        carry_nx = 1'b0;

        if (start_rise) begin
            state_nx = (state == ST_RUN) ? ST_STOP : ST_RUN;
        end

        // Only an undisturbed RUN cycle keeps the prescaler moving; a stop
        // edge or a clear discards the partial second.
        if (!CLR && !start_rise && (state == ST_RUN)) begin
            presc_nx = tick ? '0 : presc + PW'(1);
        end

        if (CLR) begin
            ones_nx = '0;
            tens_nx = '0;
        end else if (tick && !start_rise) begin
            if (ones != 4'd9) begin
                ones_nx = ones + 4'd1;
            end else if (tens != 4'd5) begin
                ones_nx = '0;
                tens_nx = tens + 4'd1;
            end else begin
                ones_nx  = '0;
                tens_nx  = '0;
                carry_nx = 1'b1;
            end
        end
    end

    assign RUNNING = (state == ST_RUN);
    assign DIG_L   = ones;
    assign DIG_H   = ((BLANK_LZ != 0) && (tens == 4'd0)) ? 4'hF : tens;

endmodule

// File: tb/tb_sec60_ctrl.sv
// Directed bench for sec60_ctrl: two instances (leading-zero blanking on and
// off) share stimulus; expected outputs go through a scoreboard queue.
`timescale 1ns/1ps

module tb_sec60_ctrl;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       CLR;
    logic [3:0] a_dig_l, a_dig_h, b_dig_l, b_dig_h;
    logic       a_carry, a_running, b_carry, b_running;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [19:0] exp;
    } exp_t;

    exp_t sb[$];

    sec60_ctrl #(.PRESCALE(4), .BLANK_LZ(1)) u_a (
        .CLK(CLK), .RST(RST), .START(START), .CLR(CLR),
        .DIG_L(a_dig_l), .DIG_H(a_dig_h), .CARRY(a_carry), .RUNNING(a_running)
    );

    sec60_ctrl #(.PRESCALE(4), .BLANK_LZ(0)) u_b (
        .CLK(CLK), .RST(RST), .START(START), .CLR(CLR),
        .DIG_L(b_dig_l), .DIG_H(b_dig_h), .CARRY(b_carry), .RUNNING(b_running)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Expected view of both instances for a given seconds value.
    function automatic logic [19:0] pack(input int tens, input int ones,
                                         input logic carry, input logic run);
        logic [3:0] t;
        logic [3:0] o;
        logic [3:0] th;
        t  = 4'(tens);
        o  = 4'(ones);
        th = (tens == 0) ? 4'hF : t;
        return {th, o, carry, run, t, o, carry, run};
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [19:0] obs;
        obs = {a_dig_h, a_dig_l, a_carry, a_running,
               b_dig_h, b_dig_l, b_carry, b_running};
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic cycle(input logic s, input logic c, input logic r,
                         input string tag, input int tens, input int ones,
                         input logic carry, input logic run);
        exp_t e;
        START = s;
        CLR   = c;
        RST   = r;
        e.tag = tag;
        e.exp = pack(tens, ones, carry, run);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check_out();
    endtask

    // Free running: m edges after entering RUN (or releasing CLR) the value
    // is base + m/4 seconds, with CARRY on the edge that lands on a multiple of 60.
    task automatic run_span(input string tag, input int base, input int m0, input int m1);
        int n;
        for (int m = m0; m <= m1; m++) begin
            n = base + m / 4;
            cycle(1'b0, 1'b0, 1'b0, tag, (n % 60) / 10, n % 10,
                  ((m % 4) == 0) && (m > 0) && ((n % 60) == 0), 1'b1);
        end
    endtask

    initial begin
        START = 1'b0;
        CLR   = 1'b0;
        RST   = 1'b1;

        cycle(1'b0, 1'b0, 1'b1, "reset", 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, "reset_hold", 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, "idle_stop", 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, "idle_stop2", 0, 0, 1'b0, 1'b0);

        // Start, then count through 59 -> 00 with carry, on to 37.
        cycle(1'b1, 1'b0, 1'b0, "start_run", 0, 0, 1'b0, 1'b1);
        run_span("count_wrap", 0, 1, 388);

        // Clear held in RUN, then restart from 00 with a full period.
        cycle(1'b0, 1'b1, 1'b0, "clr_hold", 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, "clr_hold", 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, "clr_hold", 0, 0, 1'b0, 1'b1);
        run_span("after_clr", 0, 1, 92);

        // Stop at 23 with START held two cycles (only one edge), freeze, restart.
        cycle(1'b1, 1'b0, 1'b0, "stop_23", 2, 3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, "start_held", 2, 3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, "frozen_23", 2, 3, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, "restart_23", 2, 3, 1'b0, 1'b1);
        run_span("resume", 23, 1, 7);

        // Stop edge coinciding with a tick: tick is dropped.
        cycle(1'b1, 1'b0, 1'b0, "stop_on_tick", 2, 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, "stopped_24", 2, 4, 1'b0, 1'b0);
        end

        // Clear and start edge together: digits clear and state toggles to RUN.
        cycle(1'b1, 1'b1, 1'b0, "clr_and_start", 0, 0, 1'b0, 1'b1);
        run_span("count_to_42", 0, 1, 170);

        // Reset mid-count at 42 overrides START and CLR.
        cycle(1'b1, 1'b1, 1'b1, "rst_mid", 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, "rst_mid_hold", 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, "after_rst", 0, 0, 1'b0, 1'b0);
        end

        if (sb.size() != 0) begin
            n_errors++;
            $error("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
